// File: rtl/icache_fetch_agent.sv
// Fetch request tracker in front of the icache: tags fetch PCs with slot-index txnids,
// collects out-of-order icache returns in a reorder buffer and delivers them in program order.
module icache_fetch_agent #(
  parameter int ENTRY_NUM   = 4,
  parameter int TXNID_WIDTH = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fe_req_vld,
  output logic                   fe_req_rdy,
  input  logic [ADDR_WIDTH-1:0]  fe_req_pc,
  input  logic                   fe_flush,
  output logic                   fe_rsp_vld,
  input  logic                   fe_rsp_rdy,
  output logic [ADDR_WIDTH-1:0]  fe_rsp_pc,
  output logic [DATA_WIDTH-1:0]  fe_rsp_data,
  output logic                   upstream_rxreq_vld,
  input  logic                   upstream_rxreq_rdy,
  output logic [ADDR_WIDTH-1:0]  upstream_rxreq_addr,
  output logic [TXNID_WIDTH-1:0] upstream_rxreq_txnid,
  input  logic                   upstream_txdat_vld,
  output logic                   upstream_txdat_rdy,
  input  logic [TXNID_WIDTH-1:0] upstream_txdat_txnid,
  input  logic [DATA_WIDTH-1:0]  upstream_txdat_data,
  output logic                   err
);
  localparam int PTR_W = $clog2(ENTRY_NUM);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(ENTRY_NUM);

  logic [ENTRY_NUM-1:0]   valid_q, valid_d, done_q, done_d, killed_q, killed_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   req_vld_q, req_vld_d;
  logic [TXNID_WIDTH-1:0] req_txnid_q, req_txnid_d;
  logic [ADDR_WIDTH-1:0]  req_addr_q;
  logic                   err_q, err_d;
  logic [ADDR_WIDTH-1:0]  pc_q   [ENTRY_NUM];
  logic [DATA_WIDTH-1:0]  data_q [ENTRY_NUM];

  logic             alloc, head_done, rsp_vld, retire, ret_in_range, ret_ok;
  logic [PTR_W-1:0] ret_slot;

  assign ret_slot     = upstream_txdat_txnid[PTR_W-1:0];
  // txnids beyond the buffer depth have nonzero bits above the slot index
  assign ret_in_range = ((upstream_txdat_txnid >> PTR_W) == '0);
  assign ret_ok       = upstream_txdat_vld & ret_in_range &
                        valid_q[ret_slot] & ~done_q[ret_slot];

  assign fe_req_rdy = (cnt_q < FULL) & (~req_vld_q | upstream_rxreq_rdy) & ~fe_flush;
  assign alloc      = fe_req_vld & fe_req_rdy;
  assign head_done  = valid_q[rd_ptr_q] & done_q[rd_ptr_q];
  assign rsp_vld    = head_done & ~killed_q[rd_ptr_q] & ~fe_flush;
  // killed heads drain without a front-end handshake
  assign retire     = head_done & (killed_q[rd_ptr_q] | (rsp_vld & fe_rsp_rdy));

  always_comb begin
    valid_d     = valid_q;
    done_d      = done_q;
    killed_d    = killed_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    req_vld_d   = req_vld_q;
    req_txnid_d = req_txnid_q;
    err_d       = err_q | (upstream_txdat_vld & ~ret_ok);

    if (ret_ok)
      done_d[ret_slot] = 1'b1;
    if (fe_flush)
      killed_d = killed_q | valid_q;
    if (retire) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (upstream_rxreq_rdy)
      req_vld_d = 1'b0;
    if (alloc) begin
      valid_d[wr_ptr_q]  = 1'b1;
      done_d[wr_ptr_q]   = 1'b0;
      killed_d[wr_ptr_q] = 1'b0;
      wr_ptr_d           = wr_ptr_q + 1'b1;
      req_vld_d          = 1'b1;
      req_txnid_d        = TXNID_WIDTH'(wr_ptr_q);
    end

    case ({alloc, retire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      done_q      <= '0;
      killed_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      req_vld_q   <= 1'b0;
      req_txnid_q <= '0;
      err_q       <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      done_q      <= done_d;
      killed_q    <= killed_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      req_vld_q   <= req_vld_d;
      req_txnid_q <= req_txnid_d;
      err_q       <= err_d;
    end
  end

  // payload storage is qualified by the control bits and needs no reset
  always_ff @(posedge clk) begin
    if (alloc) begin
      pc_q[wr_ptr_q] <= fe_req_pc;
      req_addr_q     <= fe_req_pc;
    end
    if (ret_ok)
      data_q[ret_slot] <= upstream_txdat_data;
  end

  assign fe_rsp_vld           = rsp_vld;
  assign fe_rsp_pc            = pc_q[rd_ptr_q];
  assign fe_rsp_data          = data_q[rd_ptr_q];
  assign upstream_rxreq_vld   = req_vld_q;
  assign upstream_rxreq_addr  = req_addr_q;
  assign upstream_rxreq_txnid = req_txnid_q;
  assign upstream_txdat_rdy   = 1'b1;
  assign err                  = err_q;
endmodule
